// File: rtl/riscv_ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, divide-op decode
// and the serial divider state encoding.
package riscv_ex_pkg;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_MULHU = 4'd11;
   localparam logic [3:0] OP_DIV   = 4'd12;
   localparam logic [3:0] OP_DIVU  = 4'd13;
   localparam logic [3:0] OP_REM   = 4'd14;
   localparam logic [3:0] OP_REMU  = 4'd15;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_BUSY = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/serial_divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with RISC-V
// divide-by-zero and overflow semantics; one quotient bit per cycle.
module serial_divider
   import riscv_ex_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic            signed_op,
   input  logic            rem_op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(DIV_CYCLES);

   div_state_e      state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0] rem_r;
   logic [XLEN-1:0] quo_r;
   logic [XLEN-1:0] div_b;
   logic            neg_q;
   logic            neg_r;
   logic            rem_sel;

   logic [XLEN-1:0] a_mag;
   logic [XLEN-1:0] b_mag;
   logic [XLEN:0]   rem_sh;
   logic [XLEN-1:0] diff;
   logic            ge;

   assign a_mag  = (signed_op && a[XLEN-1]) ? -a : a;
   assign b_mag  = (signed_op && b[XLEN-1]) ? -b : b;
   // Next dividend bit enters the partial remainder from the quotient's MSB.
   assign rem_sh = {rem_r, quo_r[XLEN-1]};
   assign ge     = rem_sh >= {1'b0, div_b};
   assign diff   = rem_sh[XLEN-1:0] - div_b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= DIV_IDLE;
         cnt     <= '0;
         rem_r   <= '0;
         quo_r   <= '0;
         div_b   <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         rem_sel <= 1'b0;
      end else if (abort) begin
         state <= DIV_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start) begin
                  state   <= DIV_BUSY;
                  cnt     <= '0;
                  rem_r   <= '0;
                  quo_r   <= a_mag;
                  div_b   <= b_mag;
                  // x/0 must yield all ones, so the quotient is never negated.
                  neg_q   <= signed_op && (a[XLEN-1] ^ b[XLEN-1]) && (b != '0);
                  neg_r   <= signed_op && a[XLEN-1];
                  rem_sel <= rem_op;
               end
            end
            DIV_BUSY: begin
               rem_r <= ge ? diff : rem_sh[XLEN-1:0];
               quo_r <= {quo_r[XLEN-2:0], ge};
               if (cnt == CNT_W'(DIV_CYCLES - 1)) begin
                  state <= DIV_DONE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DIV_DONE: state <= DIV_IDLE;
            default:  state <= DIV_IDLE;
         endcase
      end
   end

   assign busy   = (state == DIV_BUSY);
   assign done   = (state == DIV_DONE);
   assign result = rem_sel ? (neg_r ? -rem_r : rem_r)
                           : (neg_q ? -quo_r : quo_r);

endmodule

// File: rtl/ex_stage.sv
// RV32IM execute stage: single-cycle ALU/MUL, serial divider with front-end
// stall, and the EX/MEM pipeline register feeding the memory stage.
module ex_stage
   import riscv_ex_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   input  logic [3:0]      alu_op,
   input  logic [XLEN-1:0] SrcA,
   input  logic [XLEN-1:0] SrcB,
   input  logic [XLEN-1:0] rs2_data_in,
   input  logic [4:0]      rd_in,
   input  logic            MemWrite_in,
   input  logic [1:0]      ResultSrc_in,
   input  logic            RegWrite_in,
   input  logic            flush,
   output logic            stall,
   output logic            out_valid,
   output logic [XLEN-1:0] ALUResult,
   output logic [XLEN-1:0] rs2_data,
   output logic [4:0]      rd_out,
   output logic            MemWrite,
   output logic [1:0]      ResultSrc,
   output logic            RegWrite
);

   localparam int SH_W = $clog2(XLEN);

   logic                   div_start;
   logic                   div_busy;
   logic                   div_done;
   logic [XLEN-1:0]        div_result;
   logic [XLEN-1:0]        alu_result;
   logic [2*XLEN-1:0]      prod;
   logic signed [XLEN-1:0] a_s;
   logic signed [XLEN-1:0] b_s;
   logic [SH_W-1:0]        shamt;

   logic                   vld_p1;
   logic [XLEN-1:0]        res_p1;
   logic [XLEN-1:0]        rs2_p1;
   logic [4:0]             rd_p1;
   logic                   mw_p1;
   logic [1:0]             rsrc_p1;
   logic                   rw_p1;

   assign div_start = in_valid && is_div_op(alu_op) && !flush;
   // Reset is folded in so random ID/EX contents cannot raise stall during reset.
   assign stall = rst_n && ((div_start && !div_busy && !div_done) || div_busy);

   serial_divider #(
      .XLEN       (XLEN),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .abort     (flush),
      .signed_op ((alu_op == OP_DIV) || (alu_op == OP_REM)),
      .rem_op    ((alu_op == OP_REM) || (alu_op == OP_REMU)),
      .a         (SrcA),
      .b         (SrcB),
      .busy      (div_busy),
      .done      (div_done),
      .result    (div_result)
   );

   assign a_s   = SrcA;
   assign b_s   = SrcB;
   assign shamt = SrcB[SH_W-1:0];
   assign prod  = {{XLEN{1'b0}}, SrcA} * {{XLEN{1'b0}}, SrcB};

   always_comb begin
      alu_result = '0;
      case (alu_op)
         OP_ADD:   alu_result = SrcA + SrcB;
         OP_SUB:   alu_result = SrcA - SrcB;
         OP_AND:   alu_result = SrcA & SrcB;
         OP_OR:    alu_result = SrcA | SrcB;
         OP_XOR:   alu_result = SrcA ^ SrcB;
         OP_SLL:   alu_result = SrcA << shamt;
         OP_SRL:   alu_result = SrcA >> shamt;
         OP_SRA:   alu_result = XLEN'(a_s >>> shamt);
         OP_SLT:   alu_result = {{(XLEN-1){1'b0}}, a_s < b_s};
         OP_SLTU:  alu_result = {{(XLEN-1){1'b0}}, SrcA < SrcB};
         OP_MUL:   alu_result = prod[XLEN-1:0];
         OP_MULHU: alu_result = prod[2*XLEN-1:XLEN];
         default:  alu_result = '0;
      endcase
   end

   // EX -> MEM register boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         res_p1  <= '0;
         rs2_p1  <= '0;
         rd_p1   <= '0;
         mw_p1   <= 1'b0;
         rsrc_p1 <= '0;
         rw_p1   <= 1'b0;
      end else if (flush || stall) begin
         vld_p1 <= 1'b0;
         mw_p1  <= 1'b0;
         rw_p1  <= 1'b0;
      end else begin
         vld_p1  <= in_valid;
         res_p1  <= div_done ? div_result : alu_result;
         rs2_p1  <= rs2_data_in;
         rd_p1   <= rd_in;
         mw_p1   <= MemWrite_in && in_valid;
         rsrc_p1 <= ResultSrc_in;
         rw_p1   <= RegWrite_in && in_valid;
      end
   end

   assign out_valid = vld_p1;
   assign ALUResult = res_p1;
   assign rs2_data  = rs2_p1;
   assign rd_out    = rd_p1;
   assign MemWrite  = mw_p1;
   assign ResultSrc = rsrc_p1;
   assign RegWrite  = rw_p1;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: cycle-level reference model with a per-cycle compare,
// plus directed vectors pinned to hand-computed results.
module tb_ex_stage;
   import riscv_ex_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic [3:0]  alu_op = '0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic [31:0] rs2_data_in = '0;
   logic [4:0]  rd_in = '0;
   logic        MemWrite_in = 1'b0;
   logic [1:0]  ResultSrc_in = '0;
   logic        RegWrite_in = 1'b0;
   logic        flush = 1'b0;

   logic        stall;
   logic        out_valid;
   logic [31:0] ALUResult;
   logic [31:0] rs2_data;
   logic [4:0]  rd_out;
   logic        MemWrite;
   logic [1:0]  ResultSrc;
   logic        RegWrite;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .alu_op       (alu_op),
      .SrcA         (SrcA),
      .SrcB         (SrcB),
      .rs2_data_in  (rs2_data_in),
      .rd_in        (rd_in),
      .MemWrite_in  (MemWrite_in),
      .ResultSrc_in (ResultSrc_in),
      .RegWrite_in  (RegWrite_in),
      .flush        (flush),
      .stall        (stall),
      .out_valid    (out_valid),
      .ALUResult    (ALUResult),
      .rs2_data     (rs2_data),
      .rd_out       (rd_out),
      .MemWrite     (MemWrite),
      .ResultSrc    (ResultSrc),
      .RegWrite     (RegWrite)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural result of one instruction, straight from the ISA rules.
   function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      logic [63:0]        wide;
      logic               ovf;
      sa   = a;
      sb   = b;
      wide = 64'(a) * 64'(b);
      ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_ADD:   return a + b;
         OP_SUB:   return a - b;
         OP_AND:   return a & b;
         OP_OR:    return a | b;
         OP_XOR:   return a ^ b;
         OP_SLL:   return a << b[4:0];
         OP_SRL:   return a >> b[4:0];
         OP_SRA:   return sa >>> b[4:0];
         OP_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
         OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
         OP_MUL:   return wide[31:0];
         OP_MULHU: return wide[63:32];
         OP_DIV:   return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
         OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:   return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
         OP_REMU:  return (b == 0) ? a : a % b;
         default:  return 32'd0;
      endcase
   endfunction

   // Expected EX/MEM contents; div_age counts cycles since a divide was accepted.
   logic        m_valid = 1'b0;
   logic [31:0] m_res = '0;
   logic [31:0] m_rs2 = '0;
   logic [4:0]  m_rd = '0;
   logic        m_mw = 1'b0;
   logic [1:0]  m_rsrc = '0;
   logic        m_rw = 1'b0;
   int          div_age = -1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0; m_res <= '0; m_rs2 <= '0; m_rd <= '0;
         m_mw <= 1'b0; m_rsrc <= '0; m_rw <= 1'b0; div_age <= -1;
      end else if (flush || (div_age >= 0 && div_age < 32) ||
                   (div_age < 0 && in_valid && alu_op >= 4'd12)) begin
         m_valid <= 1'b0; m_mw <= 1'b0; m_rw <= 1'b0;
         div_age <= flush ? -1 : div_age + 1;
      end else begin
         m_valid <= in_valid;
         m_res   <= ref_result(alu_op, SrcA, SrcB);
         m_rs2   <= rs2_data_in;
         m_rd    <= rd_in;
         m_mw    <= MemWrite_in && in_valid;
         m_rsrc  <= ResultSrc_in;
         m_rw    <= RegWrite_in && in_valid;
         div_age <= -1;
      end
   end

   always @(negedge clk) begin
      logic exp_stall;
      exp_stall = rst_n && ((div_age >= 0 && div_age < 32) ||
                            (div_age < 0 && in_valid && alu_op >= 4'd12 && !flush));
      chk("stall",     32'(stall),     32'(exp_stall));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("ALUResult", ALUResult,      m_res);
      chk("rs2_data",  rs2_data,       m_rs2);
      chk("rd_out",    32'(rd_out),    32'(m_rd));
      chk("MemWrite",  32'(MemWrite),  32'(m_mw));
      chk("ResultSrc", 32'(ResultSrc), 32'(m_rsrc));
      chk("RegWrite",  32'(RegWrite),  32'(m_rw));
   end

   task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic mw,
                         input logic [1:0] rsrc, input logic rw);
      in_valid = 1'b1; flush = 1'b0; alu_op = op; SrcA = a; SrcB = b;
      rs2_data_in = rs2; rd_in = rd; MemWrite_in = mw; ResultSrc_in = rsrc; RegWrite_in = rw;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; flush = 1'b0; alu_op = OP_ADD; SrcA = '0; SrcB = '0;
      rs2_data_in = '0; rd_in = '0; MemWrite_in = 1'b0; ResultSrc_in = '0; RegWrite_in = 1'b0;
   endtask

   task automatic do_div(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
      int n;
      set_in(op, a, b, 32'h0, 5'd10, 1'b0, 2'd0, 1'b1);
      #1;
      n = 0;
      while (stall && n < 40) begin
         step();
         n++;
         chk({name, "_bubble_rw"}, 32'(RegWrite), 32'd0);
      end
      chk({name, "_stall_cycles"}, 32'(n), 32'd33);
      step();
      chk({name, "_result"}, ALUResult, exp);
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      idle();
   endtask

   localparam int NS = 14;
   logic [3:0]  s_op  [NS] = '{OP_ADD, OP_SRA, OP_SLTU, OP_SUB, OP_AND, OP_OR, OP_XOR,
                               OP_SLL, OP_SRL, OP_SLT, OP_SLT, OP_MUL, OP_MULHU, OP_MULHU};
   logic [31:0] s_a   [NS] = '{32'd5, 32'h8000_0000, 32'd1, 32'd10, 32'hF0F0_F0F0,
                               32'hF0F0_F0F0, 32'hFFFF_0000, 32'd1, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
   logic [31:0] s_b   [NS] = '{32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'd20, 32'hFF00_FF00,
                               32'h0F0F_0000, 32'h0F0F_0F0F, 32'h3F, 32'h24,
                               32'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 32'h0001_0000};
   logic [31:0] s_exp [NS] = '{32'd2, 32'hF800_0000, 32'd1, 32'hFFFF_FFF6, 32'hF000_F000,
                               32'hFFFF_F0F0, 32'hF0F0_0F0F, 32'h8000_0000, 32'h0800_0000,
                               32'd1, 32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd1};

   localparam int ND = 10;
   logic [3:0]  d_op  [ND] = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIV, OP_REM,
                               OP_DIVU, OP_REMU, OP_DIV, OP_REM};
   logic [31:0] d_a   [ND] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd9, 32'd9, 32'h8000_0000,
                               32'h8000_0000, 32'd100, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9};
   logic [31:0] d_b   [ND] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                               32'd7, 32'd7, 32'd0, 32'd0};
   logic [31:0] d_exp [ND] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9,
                               32'h8000_0000, 32'd0, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

   initial begin
      // Reset held with random ID/EX contents.
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'($urandom); alu_op = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
         rs2_data_in = $urandom; rd_in = 5'($urandom); MemWrite_in = 1'($urandom);
         ResultSrc_in = 2'($urandom); RegWrite_in = 1'($urandom);
         step();
         chk("reset_out_valid", 32'(out_valid), 32'd0);
         chk("reset_stall", 32'(stall), 32'd0);
         chk("reset_result", ALUResult, 32'd0);
      end
      idle();
      step();
      rst_n = 1'b1;
      repeat (3) step();
      chk("post_reset_valid", 32'(out_valid), 32'd0);
      chk("post_reset_rw", 32'(RegWrite), 32'd0);

      for (int i = 0; i < NS; i++) begin
         set_in(s_op[i], s_a[i], s_b[i], 32'h100 + 32'(i), (i == 0) ? 5'd7 : 5'(i + 1),
                1'b0, 2'd0, 1'b1);
         step();
         chk($sformatf("single_op%0d_result", i), ALUResult, s_exp[i]);
         chk($sformatf("single_op%0d_rd", i), 32'(rd_out), (i == 0) ? 32'd7 : 32'(i + 1));
         chk($sformatf("single_op%0d_valid", i), 32'(out_valid), 32'd1);
      end
      idle();
      step();

      for (int i = 0; i < ND; i++)
         do_div(d_op[i], d_a[i], d_b[i], d_exp[i], $sformatf("div%0d", i));
      step();

      // Flush in the middle of a divide.
      set_in(OP_DIV, 32'd1000, 32'd3, 32'h0, 5'd4, 1'b0, 2'd0, 1'b1);
      repeat (10) step();
      flush = 1'b1;
      step();
      chk("flush_stall", 32'(stall), 32'd0);
      chk("flush_bubble", 32'(out_valid), 32'd0);
      chk("flush_rw", 32'(RegWrite), 32'd0);
      set_in(OP_ADD, 32'd40, 32'd2, 32'h0, 5'd9, 1'b0, 2'd0, 1'b1);
      step();
      chk("after_flush_add", ALUResult, 32'd42);
      chk("after_flush_rd", 32'(rd_out), 32'd9);
      chk("after_flush_valid", 32'(out_valid), 32'd1);

      // Store issued straight after a divide completes.
      do_div(OP_DIVU, 32'd20, 32'd4, 32'd5, "div_before_sw");
      set_in(OP_ADD, 32'h0000_1000, 32'h20, 32'hCAFE_BABE, 5'd0, 1'b1, 2'd0, 1'b0);
      step();
      chk("sw_addr", ALUResult, 32'h0000_1020);
      chk("sw_data", rs2_data, 32'hCAFE_BABE);
      chk("sw_memwrite", 32'(MemWrite), 32'd1);
      chk("sw_regwrite", 32'(RegWrite), 32'd0);
      idle();
      step();

      // Asynchronous reset part-way through a divide.
      set_in(OP_ADD, 32'd7, 32'd8, 32'h0, 5'd3, 1'b0, 2'd1, 1'b1);
      step();
      set_in(OP_REM, 32'd77, 32'd5, 32'h0, 5'd6, 1'b0, 2'd0, 1'b1);
      repeat (5) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_result", ALUResult, 32'd0);
      chk("midreset_rd", 32'(rd_out), 32'd0);
      chk("midreset_stall", 32'(stall), 32'd0);
      idle();
      step();
      rst_n = 1'b1;
      set_in(OP_XOR, 32'h1234_5678, 32'hFFFF_FFFF, 32'h0, 5'd12, 1'b0, 2'd0, 1'b1);
      step();
      chk("after_reset_xor", ALUResult, 32'hEDCB_A987);
      chk("after_reset_stall", 32'(stall), 32'd0);
      idle();
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
